enc_3nrm_arbiter: RTL and testbench

ENC_3NRM_ARBITER -- requirements
Module: enc_3nrm_arbiter

---
 rtl/enc_3nrm_arbiter.sv | 122 ++++++++++++
 tb/tb_enc_3nrm_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/enc_3nrm_arbiter.sv
// Two-requester round-robin front end for a shared 3NRM encoder.
// One transaction in flight at a time: grant, start, wait for done or timeout, then hold the response.
module enc_3nrm_arbiter #(
  parameter int unsigned DONE_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        enc_start,
  output logic [15:0] enc_data,
  input  logic        enc_done,
  input  logic [63:0] enc_residues,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_residues,
  output logic        rsp_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        tmo_q, tmo_d;
  logic        grant_id;
  logic [8:0]  cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      res_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    id_d       = id_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    tmo_d      = tmo_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    enc_start  = 1'b0;
    enc_data   = '0;
    // On contention the requester not served last wins.
    grant_id   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    cnt_inc    = {1'b0, cnt_q} + 9'd1;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          data_d     = grant_id ? req1_data : req0_data;
          id_d       = grant_id;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        enc_start = 1'b1;
        enc_data  = data_q;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        enc_data = data_q;
        // A done arriving on the final count still wins over the timeout.
        if (enc_done) begin
          res_d   = enc_residues;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc[7:0];
          if (cnt_inc == 9'(DONE_TIMEOUT)) begin
            res_d   = '0;
            tmo_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign rsp_id       = id_q;
  assign rsp_residues = res_q;
  assign rsp_timeout  = tmo_q;

endmodule

// File: tb/tb_enc_3nrm_arbiter.sv
// Directed bench for enc_3nrm_arbiter with a one-cycle-latency 3NRM encoder model.
module tb_enc_3nrm_arbiter;

  localparam int unsigned DT = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        enc_start;
  logic [15:0] enc_data;
  logic        enc_done;
  logic [63:0] enc_residues;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [63:0] rsp_residues;
  logic        rsp_timeout;
  logic        busy;

  logic        auto_en = 1'b0;
  logic        force_done = 1'b0;
  logic [63:0] force_res = '0;
  logic        pend = 1'b0;
  logic [15:0] pend_data = '0;
  logic        model_done = 1'b0;
  logic [63:0] model_res = '0;

  int checks = 0;
  int errors = 0;

  enc_3nrm_arbiter #(.DONE_TIMEOUT(DT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .enc_start(enc_start), .enc_data(enc_data),
    .enc_done(enc_done), .enc_residues(enc_residues),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_residues(rsp_residues), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] enc3(input logic [15:0] d);
    return {6'(d % 64), 6'(d % 63), 7'(d % 65), 5'(d % 31), 5'(d % 29),
            5'(d % 23), 5'(d % 19), 5'(d % 17), 20'd0};
  endfunction

  // Encoder model: done pulses in the cycle after the start pulse.
  always @(negedge clk) begin
    model_done = pend;
    if (pend) model_res = enc3(pend_data);
    pend      = enc_start & auto_en;
    pend_data = enc_data;
  end

  assign enc_done     = model_done | force_done;
  assign enc_residues = force_done ? force_res : model_res;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
    chk({tag, "_enc_start"}, 64'(enc_start), 64'd0);
    chk({tag, "_enc_data"}, 64'(enc_data), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
    chk({tag, "_rsp_residues"}, rsp_residues, 64'd0);
  endtask

  initial begin
    int n;
    logic exp_id;

    // Reset values
    tick(); tick(); #1;
    chk_idle_zero("reset");
    rst_n = 1'b1;

    // Contention: grants alternate 0,1,0,1 starting with requester 0
    req0_valid = 1'b1; req0_data = 16'd0;
    req1_valid = 1'b1; req1_data = 16'd65535;
    rsp_ready = 1'b1; auto_en = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 10) begin
        tick(); #1; n++;
      end
      exp_id = 1'(k % 2);
      chk("rr_grant", 64'({req0_ready, req1_ready}), exp_id ? 64'd1 : 64'd2);
      tick(); #1;
      chk("rr_issue_ready", 64'({req0_ready, req1_ready}), 64'd0);
      tick(); #1;
      tick(); #1;
      chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rr_rsp_id", 64'(rsp_id), 64'(exp_id));
      chk("rr_rsp_res", rsp_residues, enc3(exp_id ? 16'd65535 : 16'd0));
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      tick(); #1;
    end
    chk("rr_end_idle", 64'(busy), 64'd0);

    // Single request latency: grant T, start T+1, response T+3, idle T+4
    tick(); req0_valid = 1'b1; req0_data = 16'd100; #1;
    chk("single_grant", 64'({req0_ready, req1_ready}), 64'd2);
    tick(); req0_valid = 1'b0; #1;
    chk("single_start", 64'(enc_start), 64'd1);
    chk("single_enc_data", 64'(enc_data), 64'd100);
    tick(); #1;
    chk("single_wait_nostart", 64'(enc_start), 64'd0);
    chk("single_wait_data", 64'(enc_data), 64'd100);
    chk("single_wait_norsp", 64'(rsp_valid), 64'd0);
    tick(); #1;
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_rsp_id", 64'(rsp_id), 64'd0);
    chk("single_rsp_res", rsp_residues,
        {6'd36, 6'd37, 7'd35, 5'd7, 5'd13, 5'd8, 5'd5, 5'd15, 20'd0});
    chk("single_rsp_tmo", 64'(rsp_timeout), 64'd0);
    chk("single_rsp_enc_data", 64'(enc_data), 64'd0);
    tick(); #1;
    chk("single_idle", 64'({busy, rsp_valid}), 64'd0);

    // Timeout on requester 1, then backpressure
    tick(); req1_valid = 1'b1; req1_data = 16'd7; auto_en = 1'b0; rsp_ready = 1'b0; #1;
    chk("tmo_grant", 64'({req0_ready, req1_ready}), 64'd1);
    tick(); req1_valid = 1'b0; #1;
    chk("tmo_start", 64'(enc_start), 64'd1);
    for (int i = 0; i < DT; i++) begin
      tick(); #1;
      chk("tmo_wait_norsp", 64'(rsp_valid), 64'd0);
    end
    chk("tmo_wait_data", 64'(enc_data), 64'd7);
    tick(); #1;
    chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("tmo_flag", 64'(rsp_timeout), 64'd1);
    chk("tmo_res", rsp_residues, 64'd0);
    chk("tmo_id", 64'(rsp_id), 64'd1);
    req0_valid = 1'b1; req0_data = 16'd500;
    req1_valid = 1'b1; req1_data = 16'd900;
    force_done = 1'b1; force_res = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_tmo", 64'({rsp_id, rsp_timeout}), 64'd3);
      chk("bp_res", rsp_residues, 64'd0);
      chk("bp_ready", 64'({req0_ready, req1_ready}), 64'd0);
    end
    force_done = 1'b0;
    tick(); rsp_ready = 1'b1; auto_en = 1'b1; #1;
    chk("bp_handshake_valid", 64'(rsp_valid), 64'd1);
    tick(); #1;
    chk("bp_released", 64'(rsp_valid), 64'd0);
    chk("tmo_ptr_grant", 64'({req0_ready, req1_ready}), 64'd2);
    req1_valid = 1'b0;
    tick(); req0_valid = 1'b0;
    tick();
    tick(); #1;
    chk("after_tmo_rsp", 64'({rsp_valid, rsp_id, rsp_timeout}), 64'd4);
    chk("after_tmo_res", rsp_residues, enc3(16'd500));

    // Done coinciding with the final timeout count counts as success
    tick(); req0_valid = 1'b1; req0_data = 16'd100; auto_en = 1'b0; rsp_ready = 1'b0; #1;
    chk("edge_grant", 64'({req0_ready, req1_ready}), 64'd2);
    tick(); req0_valid = 1'b0;
    for (int i = 0; i < DT; i++) begin
      tick();
      if (i == DT - 1) begin
        force_done = 1'b1; force_res = enc3(16'd100);
      end
    end
    tick(); force_done = 1'b0; rsp_ready = 1'b1; #1;
    chk("edge_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("edge_tmo", 64'(rsp_timeout), 64'd0);
    chk("edge_res", rsp_residues, enc3(16'd100));
    tick(); #1;
    chk("edge_idle", 64'(busy), 64'd0);

    // Spurious done while idle
    force_done = 1'b1; force_res = 64'h0123_4567_89AB_CDEF;
    tick(); #1;
    chk("spur_busy", 64'({busy, rsp_valid, enc_start}), 64'd0);
    chk("spur_res", rsp_residues, enc3(16'd100));
    tick(); force_done = 1'b0;

    // Async reset during WAIT drops the transaction and restores the pointer
    tick(); req1_valid = 1'b1; req1_data = 16'd9; #1;
    chk("rst_grant", 64'({req0_ready, req1_ready}), 64'd1);
    tick(); req1_valid = 1'b0;
    tick();
    tick(); #1;
    chk("rst_in_wait", 64'({busy, rsp_valid}), 64'd2);
    rst_n = 1'b0; #1;
    chk_idle_zero("rst_mid");
    tick(); rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 16'd1;
    req1_valid = 1'b1; req1_data = 16'd2;
    auto_en = 1'b1; #1;
    chk("rst_first_grant", 64'({req0_ready, req1_ready}), 64'd2);
    req1_valid = 1'b0;
    tick(); req0_valid = 1'b0;
    tick();
    tick(); #1;
    chk("rst_after_rsp", 64'({rsp_valid, rsp_id}), 64'd2);
    chk("rst_after_res", rsp_residues, enc3(16'd1));
    tick(); #1;
    chk("rst_after_idle", 64'({busy, rsp_valid}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
